inst_fetch: RTL and testbench

- Instruction fetch initiator for the pipeline front end.
- Drives chip-enable and byte address into the combinational instruction ROM, which returns the big-endian-corrected word in the same cycle.
- Captures each returned word, tagged with its PC, into a small instruction queue.
- Presents queued instructions to decode over a valid/ready handshake, and redirects fetch on branch/jump from execute.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_queue.sv | 53 +++++
 rtl/inst_fetch.sv | 63 ++++++
 tb/tb_inst_fetch.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam int                     DEFAULT_QUEUE_DEPTH = 2;
  localparam logic [INST_ADDR_W-1:0] DEFAULT_RESET_PC    = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Synchronous FIFO of {pc, inst} pairs; flush clears occupancy and pointers.
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Flush dominates so a redirect never lets a stale push or pop through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch initiator: owns the PC, issues ROM reads, queues results for decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  logic [31:0]  pc;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;
  fetch_entry_t q_wr;
  logic         unused_target_bits;

  assign unused_target_bits = ^branch_target_i[1:0];

  assign id_valid_o = ~q_empty;
  assign pop        = id_valid_o & id_ready_i & ~branch_flag_i;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign rom_ce_o   = ~rst & ~branch_flag_i & (~q_full | pop);
  assign rom_addr_o = rom_ce_o ? pc : 32'h0;

  assign id_pc_o    = id_valid_o ? q_head.pc   : 32'h0;
  assign id_inst_o  = id_valid_o ? q_head.inst : 32'h0;

  assign q_wr.pc    = pc;
  assign q_wr.inst  = rom_inst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                pc <= RESET_PC;
    else if (branch_flag_i) pc <= align_word(branch_target_i);
    else if (rom_ce_o)      pc <= pc + 32'd4;
  end

  inst_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .push   (rom_ce_o),
    .pop    (pop),
    .flush  (branch_flag_i),
    .wr_data(q_wr),
    .full   (q_full),
    .empty  (q_empty),
    .head   (q_head)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: free run, backpressure, redirect, wrap, async reset.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int checks;
  int errors;

  inst_fetch #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_ce_o       (rom_ce_o),
    .rom_addr_o     (rom_addr_o),
    .rom_inst_i     (rom_inst_i),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .id_valid_o     (id_valid_o),
    .id_ready_i     (id_ready_i),
    .id_pc_o        (id_pc_o),
    .id_inst_o      (id_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model: three fixed words, otherwise a tagged address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_0113;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    branch_flag_i   = br;
    branch_target_i = tgt;
    id_ready_i      = rdy;
    #1;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ce, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc, input logic [31:0] inst);
    checkOne({tag, ".ce"},    {31'h0, rom_ce_o},   {31'h0, ce});
    checkOne({tag, ".addr"},  rom_addr_o,          addr);
    checkOne({tag, ".valid"}, {31'h0, id_valid_o}, {31'h0, valid});
    checkOne({tag, ".pc"},    id_pc_o,             pc);
    checkOne({tag, ".inst"},  id_inst_o,           inst);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    id_ready_i      = 1'b1;
    #2;
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Free run with decode always ready.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("free0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("free1", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_0013);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("free2", 1'b1, 32'h8, 1'b1, 32'h4, 32'h0010_0093);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("free3", 1'b1, 32'hC, 1'b1, 32'h8, 32'h0020_0113);

    // Backpressure from a fresh reset.
    @(negedge clk);
    rst        = 1'b1;
    id_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("bp0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("bp1", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_0013);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("bp_full", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0013);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("bp_hold", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0013);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bp_release", 1'b1, 32'h8, 1'b1, 32'h0, 32'h0000_0013);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("bp_still_full", 1'b0, 32'h0, 1'b1, 32'h4, 32'h0010_0093);

    // Redirect with decode ready on the same cycle: flush wins.
    applyStimulus(1'b1, 32'h0000_0103, 1'b1);
    checkOutput("br_cycle", 1'b0, 32'h0, 1'b1, 32'h4, 32'h0010_0093);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("br_bubble", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("br_target", 1'b1, 32'h104, 1'b1, 32'h100, 32'hDEAD_0100);

    // Redirect held for two cycles.
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    checkOutput("br_hold0", 1'b0, 32'h0, 1'b1, 32'h104, 32'hDEAD_0104);
    applyStimulus(1'b1, 32'h0000_0300, 1'b1);
    checkOutput("br_hold1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("br_hold_resume", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);

    // PC wrap past the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    checkOutput("wrap_br", 1'b0, 32'h0, 1'b1, 32'h300, 32'hDEAD_0300);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_zero", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_full", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC);

    // Asynchronous reset between edges with two entries queued.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    id_ready_i = 1'b1;
    #1;
    checkOutput("post_rst0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("post_rst1", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_0013);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
